// File: rtl/spi_input_shifter_if.sv
// spi_input_shifter_if: pin and fsm-side signals of the SPI input shifter
interface spi_input_shifter_if #(parameter int WIDTH = 8);
  logic sclk_pin, cs_pin, mosi_pin, sr_we, miso_buff;
  logic [WIDTH-1:0] parallel_in, parallel_out;
  logic chip_sel, sclk_pos, sclk_neg, shift_reg_out, byte_done, miso_pin;
  logic [$clog2(WIDTH)-1:0] bit_count;
  modport master (
    output sclk_pin, cs_pin, mosi_pin, sr_we, parallel_in, miso_buff,
    input chip_sel, sclk_pos, sclk_neg, parallel_out, shift_reg_out, bit_count, byte_done, miso_pin
  );
  modport slave (
    input sclk_pin, cs_pin, mosi_pin, sr_we, parallel_in, miso_buff,
    output chip_sel, sclk_pos, sclk_neg, parallel_out, shift_reg_out, bit_count, byte_done, miso_pin
  );
endinterface

// File: rtl/spi_input_shifter.sv
// spi_input_shifter: SPI slave pin synchroniser, edge detector and shift register.
// Define SPI_GLITCH_FILTER_EN to add a FILTER_LEN-sample glitch filter per pin.
module spi_input_shifter #(
  parameter int WIDTH = 8,
  parameter int FILTER_LEN = 3
) (
  input logic clk,
  input logic reset,
  spi_input_shifter_if.slave bus
);
  localparam int BW = $clog2(WIDTH);
  localparam logic [2:0] RST_LVL = 3'b010;
  logic [2:0] pins, s1, s2, lvl;
  logic sclk_q, cs_q, mosi_q, pos_q, neg_q;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0] bc;
  logic bd, load_d, miso_reg, load, shift;
  assign pins = {bus.mosi_pin, bus.cs_pin, bus.sclk_pin};
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= RST_LVL;
      s2 <= RST_LVL;
    end else begin
      s1 <= pins;
      s2 <= s1;
    end
  end
`ifdef SPI_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [CW-1:0] cnt [3];
  // A level is accepted only on the FILTER_LEN-th consecutive differing sample
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        cnt[i] <= '0;
        lvl[i] <= RST_LVL[i];
      end else if (s2[i] == lvl[i]) cnt[i] <= '0;
      else if (cnt[i] == CW'(FILTER_LEN - 1)) begin
        cnt[i] <= '0;
        lvl[i] <= s2[i];
      end else cnt[i] <= cnt[i] + 1'b1;
    end
  end
`else
  assign lvl = s2;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q <= 1'b0;
      cs_q <= 1'b1;
      mosi_q <= 1'b0;
      pos_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      sclk_q <= lvl[0];
      cs_q <= lvl[1];
      mosi_q <= lvl[2];
      pos_q <= lvl[0] & ~sclk_q;
      neg_q <= ~lvl[0] & sclk_q;
    end
  end
  // A load from the fsm wins over a coincident shift
  assign load = bus.sr_we & ~cs_q;
  assign shift = pos_q & ~cs_q & ~bus.sr_we;
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
      bc <= '0;
      bd <= 1'b0;
      load_d <= 1'b0;
      miso_reg <= 1'b0;
    end else begin
      load_d <= load;
      bd <= shift && bc == BW'(WIDTH - 1);
      if (cs_q) bc <= '0;
      else if (shift) bc <= (bc == BW'(WIDTH - 1)) ? '0 : bc + 1'b1;
      if (load) sr <= bus.parallel_in;
      else if (shift) sr <= {sr[WIDTH-2:0], mosi_q};
      if (neg_q | load_d) miso_reg <= sr[WIDTH-1];
    end
  end
  assign bus.chip_sel = cs_q;
  assign bus.sclk_pos = pos_q;
  assign bus.sclk_neg = neg_q;
  assign bus.parallel_out = sr;
  assign bus.shift_reg_out = sr[0];
  assign bus.bit_count = bc;
  assign bus.byte_done = bd;
  assign bus.miso_pin = (bus.miso_buff & ~cs_q) ? miso_reg : 1'b0;
endmodule
